// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions for the MEM stage: control-bit indices,
// PC-source encodings and the data-memory access FSM states.
package mips_pipe_pkg;

  localparam int M_BRANCH    = 0;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 2;
  localparam int M_JUMP      = 3;
  localparam int M_BRANCHNE  = 4;

  localparam int WB_MEMTOREG = 0;
  localparam int WB_REGWRITE = 1;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'b00,
    MEM_ACCESS = 2'b01,
    MEM_DONE   = 2'b10
  } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/ready handshake between the MEM stage (master)
// and the data memory (slave).
interface mem_stage_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ready;
  logic [DW-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads every clock; a bubble clears the WB
// controls and holds the data fields.
module mem_wb_reg #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bubble,
  input  logic [1:0]    wb_d,
  input  logic [4:0]    rd_d,
  input  logic [DW-1:0] result_d,
  input  logic [DW-1:0] mdata_d,
  output logic [1:0]    wb_q,
  output logic [4:0]    rd_q,
  output logic [DW-1:0] result_q,
  output logic [DW-1:0] mdata_q
);

  // Pipeline register update: bubble or full load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q     <= 2'b00;
      rd_q     <= 5'd0;
      result_q <= '0;
      mdata_q  <= '0;
    end else if (bubble) begin
      wb_q     <= 2'b00;
    end else begin
      wb_q     <= wb_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      mdata_q  <= mdata_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: PC redirect, data-memory handshake FSM, pipeline stall and MEM/WB.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage
  import mips_pipe_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    WB_in,
  input  logic [4:0]    M_in,
  input  logic [4:0]    RdAddr_in,
  input  logic [DW-1:0] Result_in,
  input  logic [DW-1:0] RtData_in,
  input  logic [31:0]   b_tgt_in,
  input  logic          zero_in,
  input  logic [31:0]   pc_incr_in,
  input  logic [25:0]   jumpoffset_in,
  mem_stage_if.master   dmem,
  output logic          stall_out,
  output logic [1:0]    pc_src,
  output logic [31:0]   pc_target,
  output logic [1:0]    WB_out,
  output logic [4:0]    RdAddr_out,
  output logic [DW-1:0] Result_out,
  output logic [DW-1:0] MemData_out,
  output logic          mem_err
);

  mem_state_e    state_r, state_next_s;
  logic          req_r, we_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r, mdata_r;
  logic          memop_s, take_s, timeout_s, abort_s;
  logic [1:0]    wb_d_s;
  logic [DW-1:0] mdata_d_s;

  assign memop_s = M_in[M_MEMREAD] | M_in[M_MEMWRITE];
  assign take_s  = (M_in[M_BRANCH] & zero_in) | (M_in[M_BRANCHNE] & ~zero_in);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_r;
  logic          err_r;

  assign timeout_s = (state_r == MEM_ACCESS) & ~dmem.dmem_ready & (cnt_r == CW'(TIMEOUT - 1));
  assign abort_s   = err_r;
  assign mem_err   = err_r;

  // Counts ACCESS cycles without ready; err_r marks the aborted DONE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      err_r <= 1'b0;
    end else begin
      err_r <= timeout_s;
      if ((state_r == MEM_ACCESS) && !dmem.dmem_ready) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= '0;
      end
    end
  end
`else
  assign timeout_s = 1'b0;
  assign abort_s   = 1'b0;
  assign mem_err   = 1'b0;
`endif

  // PC redirect; only an IDLE stage owns the instruction in EX/MEM
  always_comb begin
    pc_src    = PC_SRC_SEQ;
    pc_target = 32'd0;
    if (state_r != MEM_IDLE) begin
      pc_src    = PC_SRC_SEQ;
      pc_target = 32'd0;
    end else if (M_in[M_JUMP]) begin
      pc_src    = PC_SRC_JUMP;
      pc_target = {pc_incr_in[31:28], jumpoffset_in, 2'b00};
    end else if (take_s) begin
      pc_src    = PC_SRC_BRANCH;
      pc_target = b_tgt_in;
    end else begin
      pc_src    = PC_SRC_SEQ;
      pc_target = 32'd0;
    end
  end

  // Access FSM next-state
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      MEM_IDLE:   state_next_s = memop_s ? MEM_ACCESS : MEM_IDLE;
      MEM_ACCESS: state_next_s = (dmem.dmem_ready | timeout_s) ? MEM_DONE : MEM_ACCESS;
      MEM_DONE:   state_next_s = MEM_IDLE;
      default:    state_next_s = MEM_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= MEM_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request registers latched on entry to ACCESS, read data captured on exit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      mdata_r <= '0;
    end else begin
      case (state_r)
        MEM_IDLE: begin
          if (memop_s) begin
            req_r   <= 1'b1;
            we_r    <= M_in[M_MEMWRITE];
            addr_r  <= AW'(Result_in);
            wdata_r <= RtData_in;
          end
        end
        MEM_ACCESS: begin
          if (dmem.dmem_ready) begin
            req_r   <= 1'b0;
            mdata_r <= we_r ? '0 : dmem.dmem_rdata;
          end else if (timeout_s) begin
            req_r   <= 1'b0;
            mdata_r <= '0;
          end
        end
        MEM_DONE: req_r <= 1'b0;
        default:  req_r <= 1'b0;
      endcase
    end
  end

  assign dmem.dmem_req   = req_r;
  assign dmem.dmem_we    = we_r;
  assign dmem.dmem_addr  = addr_r;
  assign dmem.dmem_wdata = wdata_r;

  assign stall_out = ~rst & (((state_r == MEM_IDLE) & memop_s) | (state_r == MEM_ACCESS));
  assign wb_d_s    = ((state_r == MEM_DONE) & abort_s) ? 2'b00 : WB_in;
  assign mdata_d_s = (state_r == MEM_DONE) ? mdata_r : '0;

  mem_wb_reg #(.DW(DW)) u_mem_wb_reg (
    .clk      (clk),
    .rst      (rst),
    .bubble   (stall_out),
    .wb_d     (wb_d_s),
    .rd_d     (RdAddr_in),
    .result_d (Result_in),
    .mdata_d  (mdata_d_s),
    .wb_q     (WB_out),
    .rd_q     (RdAddr_out),
    .result_q (Result_out),
    .mdata_q  (MemData_out)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (default build; timeout
// scenario exercised when MEM_TIMEOUT_EN is defined).
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [1:0]  WB_in;
  logic [4:0]  M_in;
  logic [4:0]  RdAddr_in;
  logic [31:0] Result_in;
  logic [31:0] RtData_in;
  logic [31:0] b_tgt_in;
  logic        zero_in;
  logic [31:0] pc_incr_in;
  logic [25:0] jumpoffset_in;
  logic        stall_out;
  logic [1:0]  pc_src;
  logic [31:0] pc_target;
  logic [1:0]  WB_out;
  logic [4:0]  RdAddr_out;
  logic [31:0] Result_out;
  logic [31:0] MemData_out;
  logic        mem_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_if #(.DW(32), .AW(32)) dmem_bus ();

  mem_stage #(.DW(32), .AW(32), .TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .WB_in         (WB_in),
    .M_in          (M_in),
    .RdAddr_in     (RdAddr_in),
    .Result_in     (Result_in),
    .RtData_in     (RtData_in),
    .b_tgt_in      (b_tgt_in),
    .zero_in       (zero_in),
    .pc_incr_in    (pc_incr_in),
    .jumpoffset_in (jumpoffset_in),
    .dmem          (dmem_bus.master),
    .stall_out     (stall_out),
    .pc_src        (pc_src),
    .pc_target     (pc_target),
    .WB_out        (WB_out),
    .RdAddr_out    (RdAddr_out),
    .Result_out    (Result_out),
    .MemData_out   (MemData_out),
    .mem_err       (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] wb, input logic [4:0] m, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] rt);
    WB_in = wb; M_in = m; RdAddr_in = rd; Result_in = res; RtData_in = rt;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    WB_in = 2'b00; M_in = 5'b00000; RdAddr_in = 5'd0; Result_in = 32'd0; RtData_in = 32'd0;
    b_tgt_in = 32'd0; zero_in = 1'b0; pc_incr_in = 32'd0; jumpoffset_in = 26'd0;
    dmem_bus.dmem_ready = 1'b0; dmem_bus.dmem_rdata = 32'd0;

    // reset state
    tick(); tick();
    check("rst_wb", 64'(WB_out), 64'(2'b00));
    check("rst_result", 64'(Result_out), 64'd0);
    check("rst_req", 64'(dmem_bus.dmem_req), 64'd0);
    check("rst_stall", 64'(stall_out), 64'd0);
    check("rst_err", 64'(mem_err), 64'd0);
    rst = 1'b0;

    // PC redirect
    M_in = 5'b00001; zero_in = 1'b1; b_tgt_in = 32'h0000_0200; #1;
    check("beq_taken_src", 64'(pc_src), 64'(2'b01));
    check("beq_taken_tgt", 64'(pc_target), 64'h200);
    zero_in = 1'b0; #1;
    check("beq_not_src", 64'(pc_src), 64'(2'b00));
    check("beq_not_tgt", 64'(pc_target), 64'h0);
    M_in = 5'b10000; #1;
    check("bne_taken_src", 64'(pc_src), 64'(2'b01));
    M_in = 5'b01001; zero_in = 1'b1; jumpoffset_in = 26'h40; pc_incr_in = 32'h9000_0004; #1;
    check("jump_src", 64'(pc_src), 64'(2'b10));
    check("jump_tgt", 64'(pc_target), 64'h9000_0100);
    zero_in = 1'b0;

    // non-memory op: one clock to MEM/WB
    drive(2'b10, 5'b00000, 5'd5, 32'h1234, 32'h0);
    check("alu_stall", 64'(stall_out), 64'd0);
    tick();
    check("alu_wb", 64'(WB_out), 64'(2'b10));
    check("alu_result", 64'(Result_out), 64'h1234);
    check("alu_rd", 64'(RdAddr_out), 64'd5);

    // load with ready on the second ACCESS cycle
    drive(2'b11, 5'b00010, 5'd7, 32'h100, 32'h0);
    check("ld_idle_stall", 64'(stall_out), 64'd1);
    check("ld_idle_req", 64'(dmem_bus.dmem_req), 64'd0);
    tick();
    check("ld_acc1_req", 64'(dmem_bus.dmem_req), 64'd1);
    check("ld_acc1_we", 64'(dmem_bus.dmem_we), 64'd0);
    check("ld_acc1_addr", 64'(dmem_bus.dmem_addr), 64'h100);
    check("ld_acc1_stall", 64'(stall_out), 64'd1);
    check("ld_acc1_wb", 64'(WB_out), 64'(2'b00));
    tick();
    check("ld_acc2_req", 64'(dmem_bus.dmem_req), 64'd1);
    check("ld_acc2_addr", 64'(dmem_bus.dmem_addr), 64'h100);
    check("ld_acc2_stall", 64'(stall_out), 64'd1);
    dmem_bus.dmem_ready = 1'b1; dmem_bus.dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_bus.dmem_ready = 1'b0; dmem_bus.dmem_rdata = 32'hDEAD_BEEF; #1;
    check("ld_done_stall", 64'(stall_out), 64'd0);
    check("ld_done_req", 64'(dmem_bus.dmem_req), 64'd0);
    check("ld_done_wb", 64'(WB_out), 64'(2'b00));
    tick();
    check("ld_wb", 64'(WB_out), 64'(2'b11));
    check("ld_memdata", 64'(MemData_out), 64'hCAFE_F00D);
    check("ld_result", 64'(Result_out), 64'h100);
    check("ld_rd", 64'(RdAddr_out), 64'd7);
    drive(2'b00, 5'b00000, 5'd0, 32'h55, 32'h0);
    tick();
    check("ld_once_wb", 64'(WB_out), 64'(2'b00));

    // store (read+write set, branch taken) -> write wins, redirect suppressed in ACCESS
    zero_in = 1'b1; b_tgt_in = 32'h300;
    drive(2'b00, 5'b00111, 5'd9, 32'h40, 32'hA5A5);
    check("st_idle_pcsrc", 64'(pc_src), 64'(2'b01));
    check("st_idle_stall", 64'(stall_out), 64'd1);
    tick();
    check("st_we", 64'(dmem_bus.dmem_we), 64'd1);
    check("st_wdata", 64'(dmem_bus.dmem_wdata), 64'hA5A5);
    check("st_addr", 64'(dmem_bus.dmem_addr), 64'h40);
    check("st_req", 64'(dmem_bus.dmem_req), 64'd1);
    check("st_acc_pcsrc", 64'(pc_src), 64'(2'b00));
    dmem_bus.dmem_ready = 1'b1;
    tick();
    dmem_bus.dmem_ready = 1'b0;
    tick();
    check("st_wb", 64'(WB_out), 64'(2'b00));
    check("st_result", 64'(Result_out), 64'h40);
    zero_in = 1'b0;
    drive(2'b00, 5'b00000, 5'd0, 32'h55, 32'h0);
    tick();
    check("nop_result", 64'(Result_out), 64'h55);

    // reset during ACCESS
    drive(2'b11, 5'b00010, 5'd4, 32'h80, 32'h0);
    tick();
    check("rstacc_req_before", 64'(dmem_bus.dmem_req), 64'd1);
    #2 rst = 1'b1; #1;
    check("rstacc_req", 64'(dmem_bus.dmem_req), 64'd0);
    check("rstacc_stall", 64'(stall_out), 64'd0);
    check("rstacc_wb", 64'(WB_out), 64'(2'b00));
    check("rstacc_result", 64'(Result_out), 64'd0);
    tick();
    rst = 1'b0;
    drive(2'b10, 5'b00000, 5'd3, 32'h77, 32'h0);
    check("rstrel_stall", 64'(stall_out), 64'd0);
    check("rstrel_req", 64'(dmem_bus.dmem_req), 64'd0);
    tick();
    check("rstrel_wb", 64'(WB_out), 64'(2'b10));
    check("rstrel_result", 64'(Result_out), 64'h77);

    // memory never ready
    drive(2'b11, 5'b00010, 5'd6, 32'h1C0, 32'h0);
`ifdef MEM_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("to_wait_err", 64'(mem_err), 64'd0);
      check("to_wait_req", 64'(dmem_bus.dmem_req), 64'd1);
    end
    tick();
    check("to_err_pulse", 64'(mem_err), 64'd1);
    check("to_req_drop", 64'(dmem_bus.dmem_req), 64'd0);
    check("to_stall", 64'(stall_out), 64'd0);
    tick();
    check("to_err_end", 64'(mem_err), 64'd0);
    check("to_wb", 64'(WB_out), 64'(2'b00));
    check("to_memdata", 64'(MemData_out), 64'd0);
    check("to_result", 64'(Result_out), 64'h1C0);
`else
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("wait_err", 64'(mem_err), 64'd0);
      check("wait_req", 64'(dmem_bus.dmem_req), 64'd1);
      check("wait_stall", 64'(stall_out), 64'd1);
    end
    dmem_bus.dmem_ready = 1'b1; dmem_bus.dmem_rdata = 32'h1357_9BDF;
    tick();
    dmem_bus.dmem_ready = 1'b0;
    tick();
    check("late_wb", 64'(WB_out), 64'(2'b11));
    check("late_memdata", 64'(MemData_out), 64'h1357_9BDF);
`endif
    drive(2'b00, 5'b00000, 5'd0, 32'h0, 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
